// File: rtl/ad9235_capture_axil_if.sv
// AXI4-Lite slave bus bundle for the AD9235 capture block.
// Ports: write address/data/response channels and read address/data channels.
// The slave modport is used by the DUT and the master modport by the initiator.
interface ad9235_capture_axil_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ad9235_capture_axil.sv
// N-channel AD9235 capture: divided encode clock, pipeline flush, per-channel FIFOs, AXI4-Lite regs.
// Latency: AXI response one cycle after the ready pulse; a sample lands in its FIFO on its strobe edge.
// Backpressure: one outstanding AXI op per direction; full FIFO drops and flags overflow. Macro AD9235_OTR_EN adds adc_otr.
// Ports: ACLK/ARESET, s_axi (AXI4-Lite slave), adc_clk (encode clock out), adc_data (packed channels), irq.
module ad9235_capture_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 2,
  parameter int ADC_WIDTH          = 12,
  parameter int FIFO_DEPTH         = 16,
  parameter int PIPE_LAT           = 7
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  ad9235_capture_axil_if.slave        s_axi,
  output logic                        adc_clk,
  input  logic [NUM_CH*ADC_WIDTH-1:0] adc_data,
`ifdef AD9235_OTR_EN
  input  logic [NUM_CH-1:0]           adc_otr,
`endif
  output logic                        irq
);
  localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = ADC_WIDTH + 1;  // sample plus out-of-range bit
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
  logic en, oneshot, done_q, irq_q, adc_clk_q;
  logic [7:0] div, div_cnt, flush_cnt;
  logic [31:0] count, sample_cnt;
  logic [1:0] irq_en;
  logic [NUM_CH-1:0] ovf, ovf_set, full_v, empty_v, pop_v, push_v, otr_in;
  logic [SW-1:0] head [NUM_CH];
  logic otr_any;

  wire [WA-1:0] wr_word = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  wire [WA-1:0] rd_word = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  wire aw_hs = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  wire ar_hs = arready_q & s_axi.S_AXI_ARVALID;
  wire wr_ok = int'(wr_word) < 4 + NUM_CH;
  wire rd_ok = int'(rd_word) < 4 + NUM_CH;
  wire wr_en = aw_hs & wr_ok;
  wire clr   = wr_en & (int'(wr_word) == 0) & s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[2];
  wire strobe = (state != S_IDLE) & (div_cnt == div) & ~adc_clk_q;
  wire reached = oneshot & (sample_cnt == count);
  wire flush_done = (PIPE_LAT == 0) || (strobe && flush_cnt == 8'(PIPE_LAT - 1));
  logic push_en;

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign adc_clk = adc_clk_q;
  assign irq     = irq_q;

`ifdef AD9235_OTR_EN
  assign otr_in = adc_otr;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                        otr_any <= 1'b0;
    else if (clr)                      otr_any <= 1'b0;
    else if (|(push_v & otr_in))       otr_any <= 1'b1;
  end
`else
  assign otr_in  = '0;
  assign otr_any = 1'b0;
`endif

  // FSM: EN low forces IDLE from any state, so a stopped run never pushes a partial sample.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push_en  = 1'b0;
    case (state)
      S_IDLE:  if (en) state_nx = S_FLUSH;
      S_FLUSH: if (flush_done) state_nx = S_RUN;
      S_RUN: begin
        if (reached) state_nx = S_DONE;
        else         push_en  = en & strobe;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (!en) state_nx = S_IDLE;
  end

  // Encode clock divider and run counters; all parked at zero while idle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_cnt <= '0; adc_clk_q <= 1'b0; flush_cnt <= '0; sample_cnt <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0; adc_clk_q <= 1'b0; flush_cnt <= '0; sample_cnt <= '0;
    end else begin
      if (div_cnt == div) begin
        div_cnt   <= '0;
        adc_clk_q <= ~adc_clk_q;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (state == S_FLUSH && strobe) flush_cnt <= flush_cnt + 8'd1;
      if (push_en) sample_cnt <= sample_cnt + 32'd1;
    end
  end

  // Per-channel FIFOs. A pop in the same cycle frees a slot so a push into a full FIFO survives.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wp, rp;
    assign empty_v[c] = (wp == rp);
    assign full_v[c]  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign pop_v[c]   = ar_hs && (int'(rd_word) == 4 + c) && !empty_v[c];
    assign push_v[c]  = push_en && !clr && (!full_v[c] || pop_v[c]);
    assign ovf_set[c] = push_en && !clr && full_v[c] && !pop_v[c];
    assign head[c]    = mem[rp[PW-1:0]];

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        wp <= '0; rp <= '0;
      end else if (clr) begin
        wp <= '0; rp <= '0;
      end else begin
        if (push_v[c]) wp <= wp + 1'b1;
        if (pop_v[c])  rp <= rp + 1'b1;
      end
    end

    always_ff @(posedge ACLK) begin
      if (push_v[c]) mem[wp[PW-1:0]] <= {otr_in[c], adc_data[c*ADC_WIDTH +: ADC_WIDTH]};
    end
  end

  // Control registers, sticky status and registered interrupt.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en <= 1'b0; oneshot <= 1'b0; div <= '0; count <= '0; irq_en <= '0;
      done_q <= 1'b0; ovf <= '0; irq_q <= 1'b0;
    end else begin
      if (wr_en && int'(wr_word) == 0) begin
        if (s_axi.S_AXI_WSTRB[0]) begin
          en      <= s_axi.S_AXI_WDATA[0];
          oneshot <= s_axi.S_AXI_WDATA[1];
        end
        if (s_axi.S_AXI_WSTRB[1]) div <= s_axi.S_AXI_WDATA[15:8];
      end
      if (wr_en && int'(wr_word) == 2) begin
        for (int b = 0; b < 4; b++)
          if (s_axi.S_AXI_WSTRB[b]) count[8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
      if (wr_en && int'(wr_word) == 3 && s_axi.S_AXI_WSTRB[0]) irq_en <= s_axi.S_AXI_WDATA[1:0];
      if (state == S_IDLE && state_nx == S_FLUSH) done_q <= 1'b0;
      if (state == S_DONE) begin
        done_q <= 1'b1;
        en     <= 1'b0;
      end
      ovf   <= clr ? '0 : (ovf | ovf_set);
      irq_q <= (done_q & irq_en[0]) | ((|ovf) & irq_en[1]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (int'(rd_word))
      0: begin rd_mux[0] = en; rd_mux[1] = oneshot; rd_mux[15:8] = div; end
      1: begin
        rd_mux[0]  = done_q;
        rd_mux[31] = otr_any;
        for (int c = 0; c < NUM_CH; c++) begin
          rd_mux[8+c]  = ovf[c];
          rd_mux[16+c] = empty_v[c];
          rd_mux[24+c] = full_v[c];
        end
      end
      2: rd_mux = count;
      3: rd_mux[1:0] = irq_en;
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_word) == 4 + c && !empty_v[c]) begin
        rd_mux[31] = 1'b1;
        rd_mux[30] = head[c][ADC_WIDTH];
        rd_mux[ADC_WIDTH-1:0] = head[c][ADC_WIDTH-1:0];
      end
    end
  end

  // AXI channels: ready pulses for one cycle, response follows on the next cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= RESP_OKAY;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rresp_q <= RESP_OKAY; rdata_q <= '0;
    end else begin
      awready_q <= ~awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
      if (aw_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= ~arready_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_ok ? rd_mux : '0;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ad9235_capture_axil.sv
// Directed testbench for ad9235_capture_axil: AXI4-Lite master tasks plus a ramp ADC model.
// The ramp value presented at each strobe equals the number of adc_clk rises since the test started.
module tb_ad9235_capture_axil;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic adc_clk, irq;
  logic [23:0] adc_data;
  int errors = 0;
  int checks = 0;
  int rise_total = 0;
  int rise_base = 0;
  logic [11:0] k12;
  logic [31:0] rd;
  logic [1:0] rs, ws;

  always #5 ACLK = ~ACLK;

  ad9235_capture_axil_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) bus ();

`ifdef AD9235_OTR_EN
  logic [1:0] otr = 2'b00;
`endif

  ad9235_capture_axil #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_CH(2),
    .ADC_WIDTH(12), .FIFO_DEPTH(16), .PIPE_LAT(7)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi(bus),
    .adc_clk(adc_clk),
    .adc_data(adc_data),
`ifdef AD9235_OTR_EN
    .adc_otr(otr),
`endif
    .irq(irq)
  );

  always @(posedge adc_clk) rise_total <= rise_total + 1;
  assign k12 = 12'(rise_total - rise_base);
  assign adc_data = {k12 + 12'hA00, k12};

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit got;
    resp = 2'b11;
    @(negedge ACLK);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin @(negedge ACLK); got = bus.S_AXI_AWREADY; end
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL axi_write_aw_timeout addr=%h", addr);
      return;
    end
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge ACLK);
      if (bus.S_AXI_BVALID) begin got = 1; resp = bus.S_AXI_BRESP; end
    end
    if (!got) begin checks++; errors++; $display("FAIL axi_write_b_timeout addr=%h", addr); end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit got;
    data = '1; resp = 2'b11;
    @(negedge ACLK);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin @(negedge ACLK); got = bus.S_AXI_ARREADY; end
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL axi_read_ar_timeout addr=%h", addr);
      return;
    end
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge ACLK);
      if (bus.S_AXI_RVALID) begin got = 1; data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP; end
    end
    if (!got) begin checks++; errors++; $display("FAIL axi_read_r_timeout addr=%h", addr); end
    @(posedge ACLK); #1;
  endtask

  task automatic wait_rises(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge ACLK);
      if (rise_total - rise_base >= target) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_rises got=%0d need=%0d", rise_total - rise_base, target);
    end
  endtask

  task automatic test_reset();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
         bus.S_AXI_RVALID, adc_clk, irq} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0000000",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
         bus.S_AXI_RVALID, adc_clk, irq});
    end
    ARESET = 1'b0;
    axi_read(6'h00, rd, rs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL reset_status got=%h exp=00030000", rd); end
    axi_read(6'h08, rd, rs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", rd); end
  endtask

  task automatic test_ramp();
    int r1, r2;
    logic prev;
    rise_base = rise_total;
    axi_write(6'h00, 32'h0000_0101, 4'b0011, ws);
    r1 = -1; r2 = -1; prev = adc_clk;
    for (int n = 0; n < 200 && r2 < 0; n++) begin
      @(negedge ACLK);
      if (!prev && adc_clk) begin if (r1 < 0) r1 = n; else r2 = n; end
      prev = adc_clk;
    end
    checks++; if (r2 - r1 != 4) begin errors++; $display("FAIL ramp_adc_clk_period got=%0d exp=4", r2 - r1); end
    wait_rises(10, 400);
    axi_read(6'h10, rd, rs);
    checks++; if (rd !== 32'h8000_0007) begin errors++; $display("FAIL ramp_first_data0 got=%h exp=80000007", rd); end
    axi_read(6'h14, rd, rs);
    checks++; if (rd !== 32'h8000_0A07) begin errors++; $display("FAIL ramp_first_data1 got=%h exp=80000a07", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ramp_irq got=%b exp=0", irq); end
    axi_write(6'h00, 32'h0000_0100, 4'b0011, ws);
    axi_write(6'h00, 32'h0000_0004, 4'b0011, ws);
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL ramp_after_clr_status got=%h exp=00030000", rd); end
  endtask

  task automatic test_oneshot();
    bit ok;
    axi_write(6'h08, 32'd5, 4'b1111, ws);
    axi_write(6'h0C, 32'h1, 4'b0001, ws);
    rise_base = rise_total;
    axi_write(6'h00, 32'h0000_0003, 4'b0011, ws);
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin @(negedge ACLK); if (irq) ok = 1; end
    checks++; if (!ok) begin errors++; $display("FAIL oneshot_irq got=0 exp=1"); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL oneshot_status got=%h exp=00000001", rd); end
    axi_read(6'h00, rd, rs);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=00000002", rd); end
    for (int i = 0; i < 5; i++) begin
      axi_read(6'h10, rd, rs);
      checks++;
      if (rd !== 32'h8000_0007 + 32'(i)) begin
        errors++; $display("FAIL oneshot_data0_%0d got=%h exp=%h", i, rd, 32'h8000_0007 + 32'(i));
      end
    end
    axi_read(6'h10, rd, rs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oneshot_sixth_read got=%h exp=0", rd); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0001_0001) begin errors++; $display("FAIL oneshot_status_after got=%h exp=00010001", rd); end
    axi_write(6'h0C, 32'h0, 4'b0001, ws);
    axi_write(6'h00, 32'h0000_0004, 4'b0011, ws);
  endtask

  task automatic test_overflow();
    bit ok;
    axi_write(6'h08, 32'd19, 4'b1111, ws);
    axi_write(6'h0C, 32'h3, 4'b0001, ws);
    rise_base = rise_total;
    axi_write(6'h00, 32'h0000_0003, 4'b0011, ws);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin axi_read(6'h04, rd, rs); if (rd[0]) ok = 1; end
    checks++; if (rd !== 32'h0300_0301) begin errors++; $display("FAIL ovf_status got=%h exp=03000301", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    for (int i = 0; i < 16; i++) begin
      axi_read(6'h10, rd, rs);
      checks++;
      if (rd !== 32'h8000_0007 + 32'(i)) begin
        errors++; $display("FAIL ovf_data0_%0d got=%h exp=%h", i, rd, 32'h8000_0007 + 32'(i));
      end
    end
    axi_read(6'h10, rd, rs);
    checks++; if (rd !== 32'h0 || rs !== 2'b00) begin errors++; $display("FAIL ovf_17th_read got=%h/%b exp=0/00", rd, rs); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0201_0301) begin errors++; $display("FAIL ovf_status_after got=%h exp=02010301", rd); end
  endtask

  task automatic test_clr_run();
    rise_base = rise_total;
    axi_write(6'h00, 32'h0000_1001, 4'b0011, ws);
    wait_rises(8, 2000);
    axi_write(6'h00, 32'h0000_1005, 4'b0011, ws);
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL clr_status got=%h exp=00030000", rd); end
    axi_read(6'h00, rd, rs);
    checks++; if (rd !== 32'h0000_1001) begin errors++; $display("FAIL clr_ctrl_readback got=%h exp=00001001", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq got=%b exp=0", irq); end
    axi_write(6'h00, 32'h0, 4'b0011, ws);
  endtask

  task automatic test_decode();
    axi_write(6'h00, 32'h0000_0004, 4'b0011, ws);
    axi_write(6'h04, 32'hFFFF_FFFF, 4'b1111, ws);
    checks++; if (ws !== 2'b00) begin errors++; $display("FAIL ro_write_bresp got=%b exp=00", ws); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL ro_write_ignored got=%h exp=00030000", rd); end
    axi_read(6'h3C, rd, rs);
    checks++; if (rs !== 2'b10 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%b/%h exp=10/0", rs, rd); end
    axi_write(6'h3C, 32'h1234_5678, 4'b1111, ws);
    checks++; if (ws !== 2'b10) begin errors++; $display("FAIL unmapped_write_bresp got=%b exp=10", ws); end
    axi_read(6'h14, rd, rs);
    checks++; if (rd !== 32'h0 || rs !== 2'b00) begin errors++; $display("FAIL empty_data1 got=%h/%b exp=0/00", rd, rs); end
    axi_write(6'h08, 32'h1122_3344, 4'b1111, ws);
    axi_write(6'h08, 32'hAABB_CCDD, 4'b0001, ws);
    axi_read(6'h08, rd, rs);
    checks++; if (rd !== 32'h1122_33DD) begin errors++; $display("FAIL wstrb_count got=%h exp=112233dd", rd); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rises;
    axi_write(6'h0C, 32'h3, 4'b0001, ws);
    axi_write(6'h00, 32'h0000_0001, 4'b0011, ws);
    repeat (40) @(negedge ACLK);
    bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_ARADDR = 6'h04; bus.S_AXI_ARVALID = 1'b1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      if (bus.S_AXI_ARREADY) begin @(posedge ACLK); #1 bus.S_AXI_ARVALID = 1'b0; end
      if (bus.S_AXI_RVALID) ok = 1;
    end
    bus.S_AXI_ARVALID = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_rvalid_high got=0 exp=1"); end
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin @(negedge ACLK); if (adc_clk) ok = 1; end
    #2 ARESET = 1'b1;
    #1;
    checks++;
    if ({bus.S_AXI_RVALID, adc_clk, irq} !== 3'b000) begin
      errors++; $display("FAIL rstmid_async got=%b exp=000", {bus.S_AXI_RVALID, adc_clk, irq});
    end
    repeat (2) @(negedge ACLK);
    bus.S_AXI_RREADY = 1'b1;
    ARESET = 1'b0;
    rises = rise_total;
    axi_read(6'h00, rd, rs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_ctrl got=%h exp=0", rd); end
    axi_read(6'h04, rd, rs);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL rstmid_status got=%h exp=00030000", rd); end
    repeat (20) @(negedge ACLK);
    checks++; if (rise_total != rises || adc_clk !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle_clk got=%0d rises exp=0", rise_total - rises);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_oneshot();
    test_overflow();
    test_clr_run();
    test_decode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
